// File: rtl/arp_pkg.sv
// Shared ARP constants, state encoding and the payload word builder used by the
// requester and responder.
package arp_pkg;

    localparam logic [31:0] ARP_HW_PT_WORD    = 32'h0001_0800;
    localparam logic [31:0] ARP_LEN_REQ_WORD  = 32'h0604_0001;
    localparam logic [31:0] ARP_LEN_REP_WORD  = 32'h0604_0002;
    localparam int unsigned ARP_PAYLOAD_WORDS = 7;
    localparam int unsigned ARP_IDX_W         = 3;
    localparam logic [ARP_IDX_W-1:0] ARP_LAST_IDX = ARP_IDX_W'(ARP_PAYLOAD_WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX,
        ST_WAIT,
        ST_DONE,
        ST_FAIL
    } arp_req_state_e;

    typedef struct packed {
        logic [47:0] sha;
        logic [31:0] spa;
        logic [47:0] tha;
        logic [31:0] tpa;
    } arp_addr_t;

    // Word idx of a 28-byte ARP payload in network order.
    function automatic logic [31:0] arp_word(input logic [ARP_IDX_W-1:0] idx,
                                             input logic [31:0]          oper,
                                             input arp_addr_t            addr);
        logic [31:0] w;
        w = '0;
        case (idx)
            3'd0:    w = ARP_HW_PT_WORD;
            3'd1:    w = oper;
            3'd2:    w = addr.sha[47:16];
            3'd3:    w = {addr.sha[15:0], addr.spa[31:16]};
            3'd4:    w = {addr.spa[15:0], addr.tha[47:32]};
            3'd5:    w = addr.tha[31:0];
            3'd6:    w = addr.tpa;
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/arp_rx_match.sv
// RX ARP payload parser: flags a reply from target_ip addressed to LOCAL_IP and
// captures its sender MAC.
module arp_rx_match #(
    parameter logic [31:0] LOCAL_IP = 32'hC0A8_0102
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rx_data,
    input  logic        rx_valid,
    input  logic        rx_last,
    input  logic [31:0] target_ip,
    output logic        match_c,
    output logic [47:0] sha
);
    import arp_pkg::*;

    logic [ARP_IDX_W-1:0] idx, idx_d;
    logic                 flag, flag_d;
    logic [47:0]          sha_d;

    // Index 7 marks an over-long packet; it holds there until rx_last.
    always_comb begin
        idx_d   = idx;
        flag_d  = flag;
        sha_d   = sha;
        match_c = 1'b0;
        if (rx_valid) begin
            case (idx)
                3'd0:    flag_d = (rx_data == ARP_HW_PT_WORD);
                3'd1:    flag_d = flag && (rx_data == ARP_LEN_REP_WORD);
                3'd2:    sha_d[47:16] = rx_data;
                3'd3: begin
                    sha_d[15:0] = rx_data[31:16];
                    flag_d      = flag && (rx_data[15:0] == target_ip[31:16]);
                end
                3'd4:    flag_d = flag && (rx_data[31:16] == target_ip[15:0]);
                3'd6:    match_c = rx_last && flag && (rx_data == LOCAL_IP);
                default: flag_d = flag;
            endcase
            if (rx_last) begin
                idx_d = '0;
            end else if (idx != '1) begin
                idx_d = idx + ARP_IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx  <= '0;
            flag <= 1'b0;
            sha  <= '0;
        end else begin
            idx  <= idx_d;
            flag <= flag_d;
            sha  <= sha_d;
        end
    end

endmodule

// File: rtl/arp_requester.sv
// ARP initiator: sends a Request, waits for the matching Reply with retries.
// Optional single-entry result cache enabled by defining ARP_REQ_CACHE_EN.
module arp_requester #(
    parameter logic [47:0]  LOCAL_MAC      = 48'h00_0A_35_00_00_01,
    parameter logic [31:0]  LOCAL_IP       = 32'hC0A8_0102,
    parameter int unsigned  TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned  MAX_RETRY      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_target_ip,
    output logic        o_busy,
    output logic [31:0] o_tx_data,
    output logic        o_tx_valid,
    output logic        o_tx_last,
    input  logic        i_tx_ready,
    input  logic [31:0] i_rx_data,
    input  logic        i_rx_valid,
    input  logic        i_rx_last,
    output logic        o_done,
    output logic        o_fail,
    output logic [47:0] o_mac
);
    import arp_pkg::*;

    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    arp_req_state_e       state, state_d;
    logic [ARP_IDX_W-1:0] widx, widx_d;
    logic [RETRY_W-1:0]   retry, retry_d;
    logic [TIMER_W-1:0]   timer, timer_d;
    logic [31:0]          target, target_d;
    logic                 busy_d, tx_valid_d, tx_last_d, done_d, fail_d;
    logic [31:0]          tx_data_d;
    logic [47:0]          mac_d;
    arp_addr_t            req_addr;
    logic                 rx_match_c;
    logic [47:0]          rx_sha;

    arp_rx_match #(
        .LOCAL_IP (LOCAL_IP)
    ) u_rx_match (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (i_rx_data),
        .rx_valid  (i_rx_valid),
        .rx_last   (i_rx_last),
        .target_ip (target),
        .match_c   (rx_match_c),
        .sha       (rx_sha)
    );

`ifdef ARP_REQ_CACHE_EN
    logic        cache_valid;
    logic [31:0] cache_ip;
    logic [47:0] cache_mac;
    logic        cache_hit_c;

    assign cache_hit_c = cache_valid && (i_target_ip == cache_ip);

    always_ff @(posedge clk) begin
        if (rst) begin
            cache_valid <= 1'b0;
            cache_ip    <= '0;
            cache_mac   <= '0;
        end else if (state == ST_DONE) begin
            cache_valid <= 1'b1;
            cache_ip    <= target;
            cache_mac   <= o_mac;
        end
    end
`endif

    // Next state plus next values of every registered output.
    always_comb begin
        state_d  = state;
        widx_d   = widx;
        retry_d  = retry;
        timer_d  = timer;
        target_d = target;
        mac_d    = o_mac;
        done_d   = 1'b0;
        req_addr = '0;
        case (state)
            ST_IDLE: begin
                if (i_req) begin
                    target_d = i_target_ip;
                    retry_d  = '0;
                    widx_d   = '0;
`ifdef ARP_REQ_CACHE_EN
                    if (cache_hit_c) begin
                        done_d = 1'b1;
                        mac_d  = cache_mac;
                    end else begin
                        state_d = ST_TX;
                    end
`else
                    state_d = ST_TX;
`endif
                end
            end
            ST_TX: begin
                if (i_tx_ready) begin
                    if (widx == ARP_LAST_IDX) begin
                        widx_d  = '0;
                        timer_d = TIMER_W'(TIMEOUT_CYCLES);
                        state_d = ST_WAIT;
                    end else begin
                        widx_d = widx + ARP_IDX_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                timer_d = timer - TIMER_W'(1);
                // A reply landing on the expiry cycle still wins.
                if (rx_match_c) begin
                    mac_d   = rx_sha;
                    state_d = ST_DONE;
                end else if (timer == TIMER_W'(1)) begin
                    if (retry < RETRY_W'(MAX_RETRY)) begin
                        retry_d = retry + RETRY_W'(1);
                        widx_d  = '0;
                        state_d = ST_TX;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_FAIL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        req_addr.sha = LOCAL_MAC;
        req_addr.spa = LOCAL_IP;
        req_addr.tpa = target_d;
        busy_d     = (state_d != ST_IDLE);
        tx_valid_d = (state_d == ST_TX);
        tx_last_d  = tx_valid_d && (widx_d == ARP_LAST_IDX);
        tx_data_d  = tx_valid_d ? arp_word(widx_d, ARP_LEN_REQ_WORD, req_addr) : '0;
        done_d     = done_d || (state_d == ST_DONE);
        fail_d     = (state_d == ST_FAIL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            widx       <= '0;
            retry      <= '0;
            timer      <= '0;
            target     <= '0;
            o_busy     <= 1'b0;
            o_tx_valid <= 1'b0;
            o_tx_last  <= 1'b0;
            o_tx_data  <= '0;
            o_done     <= 1'b0;
            o_fail     <= 1'b0;
            o_mac      <= '0;
        end else begin
            state      <= state_d;
            widx       <= widx_d;
            retry      <= retry_d;
            timer      <= timer_d;
            target     <= target_d;
            o_busy     <= busy_d;
            o_tx_valid <= tx_valid_d;
            o_tx_last  <= tx_last_d;
            o_tx_data  <= tx_data_d;
            o_done     <= done_d;
            o_fail     <= fail_d;
            o_mac      <= mac_d;
        end
    end

endmodule

// File: tb/tb_arp_requester.sv
// Directed bench for arp_requester: short-timeout instance (dut_a) for retry/fail,
// long-timeout instance (dut_b) for reply filtering, stalls and the cache.
module tb_arp_requester;

    localparam logic [47:0] LMAC = 48'h000A35000001;
    localparam logic [31:0] LIP  = 32'hC0A80102;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req_a, req_b, tx_ready, rx_valid, rx_last, sel;
    logic [31:0] target, rx_data;
    logic        busy_a, valid_a, last_a, done_a, fail_a;
    logic        busy_b, valid_b, last_b, done_b, fail_b;
    logic [31:0] data_a, data_b;
    logic [47:0] mac_a, mac_b;

    arp_requester #(.TIMEOUT_CYCLES(16), .MAX_RETRY(2)) dut_a (
        .clk(clk), .rst(rst), .i_req(req_a), .i_target_ip(target), .o_busy(busy_a),
        .o_tx_data(data_a), .o_tx_valid(valid_a), .o_tx_last(last_a), .i_tx_ready(tx_ready),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_rx_last(rx_last),
        .o_done(done_a), .o_fail(fail_a), .o_mac(mac_a));

    arp_requester #(.TIMEOUT_CYCLES(64), .MAX_RETRY(2)) dut_b (
        .clk(clk), .rst(rst), .i_req(req_b), .i_target_ip(target), .o_busy(busy_b),
        .o_tx_data(data_b), .o_tx_valid(valid_b), .o_tx_last(last_b), .i_tx_ready(tx_ready),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_rx_last(rx_last),
        .o_done(done_b), .o_fail(fail_b), .o_mac(mac_b));

    logic        m_busy, m_valid, m_last, m_done, m_fail;
    logic [31:0] m_data;
    logic [47:0] m_mac;
    assign m_busy  = sel ? busy_b  : busy_a;
    assign m_valid = sel ? valid_b : valid_a;
    assign m_last  = sel ? last_b  : last_a;
    assign m_data  = sel ? data_b  : data_a;
    assign m_done  = sel ? done_b  : done_a;
    assign m_fail  = sel ? fail_b  : fail_a;
    assign m_mac   = sel ? mac_b   : mac_a;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [32:0] exp_tx_q[$];
    logic [47:0] exp_mac_q[$];
    int          w0_cyc[$];
    int          w6_cyc[$];
    int          tx_pos = 0, hs_cnt = 0, fail_seen = 0, fail_cyc = 0;
    logic        prev_stall = 1'b0;
    logic [32:0] prev_word, mon_exp_w;
    logic [47:0] mon_exp_m;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: pops expected TX words and MACs as the DUT produces them.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) check("tx_hold", {m_valid, m_last, m_data}, {1'b1, prev_word});
            prev_stall = m_valid && !tx_ready;
            prev_word  = {m_last, m_data};
            if (m_valid && tx_ready) begin
                hs_cnt++;
                if (exp_tx_q.size() != 0) mon_exp_w = exp_tx_q.pop_front();
                else mon_exp_w = 'x;
                check("tx_word", {m_last, m_data}, mon_exp_w);
                if (tx_pos == 0) w0_cyc.push_back(cyc);
                if (tx_pos == 6) begin
                    w6_cyc.push_back(cyc);
                    tx_pos = 0;
                end else begin
                    tx_pos++;
                end
            end
            if (m_done) begin
                if (exp_mac_q.size() != 0) mon_exp_m = exp_mac_q.pop_front();
                else mon_exp_m = 'x;
                check("done_mac", m_mac, mon_exp_m);
            end
            if (m_fail) begin
                fail_seen++;
                fail_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_burst(input logic [31:0] ip);
        exp_tx_q.push_back({1'b0, 32'h00010800});
        exp_tx_q.push_back({1'b0, 32'h06040001});
        exp_tx_q.push_back({1'b0, 32'h000A3500});
        exp_tx_q.push_back({1'b0, 32'h0001C0A8});
        exp_tx_q.push_back({1'b0, 32'h01020000});
        exp_tx_q.push_back({1'b0, 32'h00000000});
        exp_tx_q.push_back({1'b1, ip});
    endtask

    task automatic start_req(input logic use_b, input logic [31:0] ip);
        push_burst(ip);
        target = ip;
        if (use_b) req_b = 1'b1; else req_a = 1'b1;
        tick();
        req_a = 1'b0;
        req_b = 1'b0;
        check("accept_busy", m_busy, 1);
        check("accept_w0", {m_valid, m_data}, {1'b1, 32'h00010800});
    endtask

    task automatic wait_w6(input int n);
        int k = 0;
        while (w6_cyc.size() < n && k < 300) begin
            tick();
            k++;
        end
        check("w6_reached", (w6_cyc.size() >= n), 1);
    endtask

    function automatic logic [6:0][31:0] mk_reply(input logic [47:0] sha, input logic [31:0] spa,
                                                  input logic [15:0] op);
        logic [6:0][31:0] w;
        w[0] = 32'h00010800;
        w[1] = {16'h0604, op};
        w[2] = sha[47:16];
        w[3] = {sha[15:0], spa[31:16]};
        w[4] = {spa[15:0], LMAC[47:32]};
        w[5] = LMAC[31:0];
        w[6] = LIP;
        return w;
    endfunction

    task automatic send_pkt(input logic [6:0][31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            rx_data  = w[i];
            rx_valid = 1'b1;
            rx_last  = (i == n - 1);
            tick();
        end
        rx_valid = 1'b0;
        rx_last  = 1'b0;
    endtask

    logic [47:0] mac_x;
    int          n0, n6, h0, f0, k;

    initial begin
        sel = 1'b0; rst = 1'b1; req_a = 1'b0; req_b = 1'b0; tx_ready = 1'b1;
        target = '0; rx_valid = 1'b0; rx_last = 1'b0; rx_data = '0;
        repeat (3) tick();
        check("rst_a", {busy_a, valid_a, last_a, done_a, fail_a, mac_a}, 0);
        check("rst_b", {busy_b, valid_b, last_b, done_b, fail_b, mac_b}, 0);
        rst = 1'b0;
        tick();

        // Basic resolve, reply 20 cycles after w6.
        sel = 1'b1;
        start_req(1'b1, 32'hC0A80105);
        wait_w6(1);
        repeat (19) tick();
        exp_mac_q.push_back(48'h112233445566);
        send_pkt(mk_reply(48'h112233445566, 32'hC0A80105, 16'h0002), 7);
        check("t1_done", m_done, 1);
        check("t1_mac", m_mac, 48'h112233445566);
        tick();
        check("t1_busy_drop", {m_busy, m_done}, 0);

        // Toggling tx_ready: words held while stalled, exactly 7 handshakes.
        h0 = hs_cnt;
        tx_ready = 1'b0;
        start_req(1'b1, 32'hC0A80107);
        k = 0;
        while (m_valid && k < 60) begin
            tx_ready = ~tx_ready;
            tick();
            k++;
        end
        tx_ready = 1'b1;
        check("t2_handshakes", hs_cnt - h0, 7);
        exp_mac_q.push_back(48'hA1B2C3D4E5F6);
        send_pkt(mk_reply(48'hA1B2C3D4E5F6, 32'hC0A80107, 16'h0002), 7);
        check("t2_done", m_done, 1);
        tick();

        // Short timeout: first attempt expires, reply lands in the second.
        sel = 1'b0;
        n0 = w0_cyc.size();
        n6 = w6_cyc.size();
        push_burst(32'hC0A80109);
        start_req(1'b0, 32'hC0A80109);
        wait_w6(n6 + 2);
        exp_mac_q.push_back(48'h0CAFE0000001);
        send_pkt(mk_reply(48'h0CAFE0000001, 32'hC0A80109, 16'h0002), 7);
        check("t3_done", m_done, 1);
        if (w0_cyc.size() > n0 + 1) check("t3_retry_gap", w0_cyc[n0 + 1] - w6_cyc[n6], 17);
        tick();
        check("t3_busy_drop", m_busy, 0);

        // No reply at all: three bursts then a single fail pulse.
        n0 = w0_cyc.size();
        n6 = w6_cyc.size();
        f0 = fail_seen;
        push_burst(32'hC0A8010A);
        push_burst(32'hC0A8010A);
        start_req(1'b0, 32'hC0A8010A);
        k = 0;
        while (fail_seen == f0 && k < 300) begin
            tick();
            k++;
        end
        check("t4_fail_pulse", fail_seen - f0, 1);
        check("t4_busy_drop", m_busy, 0);
        check("t4_bursts", w6_cyc.size() - n6, 3);
        if (w6_cyc.size() >= n6 + 3 && w0_cyc.size() >= n0 + 3) begin
            check("t4_gap1", w0_cyc[n0 + 1] - w6_cyc[n6], 17);
            check("t4_gap2", w0_cyc[n0 + 2] - w6_cyc[n6 + 1], 17);
            check("t4_fail_time", fail_cyc - w6_cyc[n6 + 2], 17);
        end
        repeat (5) tick();
        check("t4_fail_once", fail_seen - f0, 1);
        check("t4_no_extra_tx", exp_tx_q.size(), 0);

        // Bad replies are ignored; only the valid one completes.
        sel = 1'b1;
        mac_x = 48'h5A5A00C0FFEE;
        start_req(1'b1, 32'hC0A8010B);
        wait_w6(w6_cyc.size() + 1);
        send_pkt(mk_reply(mac_x, 32'hC0A80199, 16'h0002), 7);
        check("t5_wrong_spa", m_done, 0);
        send_pkt(mk_reply(mac_x, 32'hC0A8010B, 16'h0001), 7);
        check("t5_opcode1", m_done, 0);
        send_pkt(mk_reply(mac_x, 32'hC0A8010B, 16'h0002), 5);
        check("t5_truncated", m_done, 0);
        exp_mac_q.push_back(mac_x);
        send_pkt(mk_reply(mac_x, 32'hC0A8010B, 16'h0002), 7);
        check("t5_done", m_done, 1);
        check("t5_mac", m_mac, mac_x);
        tick();

        // Re-request of the same IP.
        h0 = hs_cnt;
`ifdef ARP_REQ_CACHE_EN
        exp_mac_q.push_back(mac_x);
        target = 32'hC0A8010B;
        req_b = 1'b1;
        tick();
        req_b = 1'b0;
        check("t6_cache_done", {m_done, m_busy, m_valid}, 3'b100);
        check("t6_cache_mac", m_mac, mac_x);
        tick();
        check("t6_cache_idle", {m_done, m_busy, m_valid}, 0);
        check("t6_cache_no_tx", hs_cnt - h0, 0);
`else
        start_req(1'b1, 32'hC0A8010B);
        wait_w6(w6_cyc.size() + 1);
        check("t6_retransmit", hs_cnt - h0, 7);
        exp_mac_q.push_back(mac_x);
        send_pkt(mk_reply(mac_x, 32'hC0A8010B, 16'h0002), 7);
        check("t6_done", m_done, 1);
        tick();
`endif

        repeat (3) tick();
        check("end_tx_queue", exp_tx_q.size(), 0);
        check("end_mac_queue", exp_mac_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
